// File: rtl/drbg_sync_pkg.sv
// Shared state encoding and default constants for the DRBG sequence tracker.
// Optional statistics outputs are enabled by DRBG_SEQ_TRACKER_STATS_EN.
package drbg_sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COMPARE  = 3'd1,
        ST_CATCH_UP = 3'd2,
        ST_WAIT     = 3'd3,
        ST_RESET    = 3'd4,
        ST_INIT     = 3'd5
    } trk_state_e;

    localparam int DEF_SEQ_W        = 32;
    localparam int DEF_MAX_LEAD     = 60;
    localparam int DEF_MAX_LAG      = 1024;
    localparam int DEF_INIT_TIMEOUT = 4096;

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/drbg_seq_delta.sv
// Wrap-aware distance between received and local sequence numbers,
// classified into zero / lag (catch up) / lead (wait) / far (reset).
module drbg_seq_delta
    import drbg_sync_pkg::*;
#(
    parameter int SEQ_W    = DEF_SEQ_W,
    parameter int MAX_LEAD = DEF_MAX_LEAD,
    parameter int MAX_LAG  = DEF_MAX_LAG
) (
    input  logic [SEQ_W-1:0] ext_seq,
    input  logic [SEQ_W-1:0] int_seq,
    output logic             zone_zero,
    output logic             zone_lag,
    output logic             zone_lead,
    output logic             zone_far
);

    localparam logic signed [SEQ_W-1:0] ZERO = '0;
    localparam logic signed [SEQ_W-1:0] LAG  = SEQ_W'(MAX_LAG);
    localparam logic signed [SEQ_W-1:0] LEAD = -(SEQ_W'(MAX_LEAD));

    logic signed [SEQ_W-1:0] delta;

    // Modular difference read as two's complement gives the shortest signed distance.
    always_comb begin
        delta     = $signed(ext_seq - int_seq);
        zone_zero = (delta == ZERO);
        zone_lag  = (delta > ZERO) && (delta <= LAG);
        zone_lead = (delta < ZERO) && (delta >= LEAD);
        zone_far  = !(zone_zero || zone_lag || zone_lead);
    end

endmodule

// File: rtl/drbg_seq_tracker.sv
// Keeps the local DRBG sequence aligned with a received sequence number.
// Define DRBG_SEQ_TRACKER_STATS_EN to add resync/catch-up counters.
module drbg_seq_tracker
    import drbg_sync_pkg::*;
#(
    parameter int SEQ_W        = DEF_SEQ_W,
    parameter int MAX_LEAD     = DEF_MAX_LEAD,
    parameter int MAX_LAG      = DEF_MAX_LAG,
    parameter int INIT_TIMEOUT = DEF_INIT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             init_done,
    input  logic [SEQ_W-1:0] seq_internal,
    input  logic [SEQ_W-1:0] seq_external,
    input  logic             seq_external_valid,
    input  logic             v_ready,
    output logic             catch_up_mode,
    output logic             get_next_seed,
    output logic             do_init,
    output logic             block_drbg_reseed,
    output logic             sync_locked,
    output logic             sync_error,
    output logic             reset_n_drbg
`ifdef DRBG_SEQ_TRACKER_STATS_EN
    ,
    output logic [15:0]      resync_count,
    output logic [15:0]      catchup_count
`endif
);

    localparam int TW = $clog2(INIT_TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(INIT_TIMEOUT - 1);

    trk_state_e       state_q, state_d;
    logic [SEQ_W-1:0] ext_q, ext_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             valid_q;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             cu_q, cu_d;
    logic             blk_q, blk_d;
    logic             init_q, init_d;
    logic             drst_q, drst_d;

    logic             rise;
    logic             target;
    logic             z_zero, z_lag, z_lead, z_far;

    drbg_seq_delta #(
        .SEQ_W    (SEQ_W),
        .MAX_LEAD (MAX_LEAD),
        .MAX_LAG  (MAX_LAG)
    ) u_delta (
        .ext_seq   (ext_q),
        .int_seq   (seq_internal),
        .zone_zero (z_zero),
        .zone_lag  (z_lag),
        .zone_lead (z_lead),
        .zone_far  (z_far)
    );

    // Next state, stored target and registered output values.
    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        timer_d  = timer_q;
        locked_d = locked_q;
        err_d    = 1'b0;

        rise   = seq_external_valid && !valid_q;
        target = ((seq_internal == ext_q) && v_ready) ||
                 ((seq_internal == (ext_q - SEQ_W'(1))) && !v_ready);

        if (rise) begin
            ext_d = seq_external;
        end

        case (state_q)
            ST_COMPARE: begin
                if (!rise) begin
                    unique case (1'b1)
                        z_zero: begin
                            state_d  = ST_IDLE;
                            locked_d = 1'b1;
                        end
                        z_lag:  state_d = ST_CATCH_UP;
                        z_lead: state_d = ST_WAIT;
                        z_far:  state_d = ST_RESET;
                    endcase
                end
            end
            ST_CATCH_UP, ST_WAIT: begin
                if (rise) begin
                    state_d  = ST_COMPARE;
                    locked_d = 1'b0;
                end else if (target) begin
                    state_d  = ST_IDLE;
                    locked_d = 1'b1;
                end
            end
            ST_RESET: begin
                state_d = ST_INIT;
                timer_d = '0;
            end
            ST_INIT: begin
                if (init_done) begin
                    state_d = ST_COMPARE;
                end else if (timer_q == T_LAST) begin
                    state_d = ST_RESET;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                if (rise) begin
                    state_d = ST_COMPARE;
                end
            end
        endcase

        if (state_d == ST_RESET) begin
            locked_d = 1'b0;
        end

        cu_d   = (state_d == ST_CATCH_UP);
        blk_d  = (state_d == ST_WAIT);
        init_d = (state_d == ST_INIT);
        drst_d = (state_d != ST_RESET);
    end

    // State, stored target and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ext_q    <= '0;
            timer_q  <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cu_q     <= 1'b0;
            blk_q    <= 1'b0;
            init_q   <= 1'b0;
            drst_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            ext_q    <= ext_d;
            timer_q  <= timer_d;
            valid_q  <= seq_external_valid;
            locked_q <= locked_d;
            err_q    <= err_d;
            cu_q     <= cu_d;
            blk_q    <= blk_d;
            init_q   <= init_d;
            drst_q   <= drst_d;
        end
    end

    assign catch_up_mode     = cu_q;
    assign get_next_seed     = cu_q;
    assign block_drbg_reseed = blk_q;
    assign do_init           = init_q;
    assign sync_locked       = locked_q;
    assign sync_error        = err_q;
    assign reset_n_drbg      = reset_n & drst_q;

`ifdef DRBG_SEQ_TRACKER_STATS_EN
    logic [15:0] rsc_q, rsc_d;
    logic [15:0] cuc_q, cuc_d;

    // Saturating counts of resync and catch-up entries.
    always_comb begin
        rsc_d = rsc_q;
        cuc_d = cuc_q;
        if ((state_d == ST_RESET) && (state_q != ST_RESET) &&
            (rsc_q != STAT_MAX)) begin
            rsc_d = rsc_q + 16'd1;
        end
        if ((state_d == ST_CATCH_UP) && (state_q != ST_CATCH_UP) &&
            (cuc_q != STAT_MAX)) begin
            cuc_d = cuc_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsc_q <= '0;
            cuc_q <= '0;
        end else begin
            rsc_q <= rsc_d;
            cuc_q <= cuc_d;
        end
    end

    assign resync_count  = rsc_q;
    assign catchup_count = cuc_q;
`endif

endmodule

// File: tb/tb_drbg_seq_tracker.sv
// Directed bench for drbg_seq_tracker with a cycle model and per-cycle compare.
// Stats checks compile in when DRBG_SEQ_TRACKER_STATS_EN is defined.
module tb_drbg_seq_tracker;

    localparam int LAG  = 1024;
    localparam int LEAD = 60;
    localparam int TMO  = 4096;

    localparam int M_IDLE = 0;
    localparam int M_CMP  = 1;
    localparam int M_CU   = 2;
    localparam int M_WAIT = 3;
    localparam int M_RST  = 4;
    localparam int M_INIT = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_done = 1'b0;
    logic [31:0] seq_internal = '0;
    logic [31:0] seq_external = '0;
    logic        seq_external_valid = 1'b0;
    logic        v_ready = 1'b0;
    logic        catch_up_mode, get_next_seed, do_init;
    logic        block_drbg_reseed, sync_locked, sync_error;
    logic        reset_n_drbg;
`ifdef DRBG_SEQ_TRACKER_STATS_EN
    logic [15:0] resync_count, catchup_count;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int          m_mode = M_IDLE;
    logic [31:0] m_ext = '0;
    bit          m_prev = 1'b0;
    bit          m_locked = 1'b0;
    bit          m_err = 1'b0;
    int          m_timer = 0;
    int          m_rsc = 0;
    int          m_cuc = 0;

    drbg_seq_tracker dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .init_done          (init_done),
        .seq_internal       (seq_internal),
        .seq_external       (seq_external),
        .seq_external_valid (seq_external_valid),
        .v_ready            (v_ready),
        .catch_up_mode      (catch_up_mode),
        .get_next_seed      (get_next_seed),
        .do_init            (do_init),
        .block_drbg_reseed  (block_drbg_reseed),
        .sync_locked        (sync_locked),
        .sync_error         (sync_error),
        .reset_n_drbg       (reset_n_drbg)
`ifdef DRBG_SEQ_TRACKER_STATS_EN
        ,
        .resync_count       (resync_count),
        .catchup_count      (catchup_count)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic enter(input int nm);
        if (nm == M_RST && m_mode != M_RST && m_rsc < 16'hFFFF) m_rsc++;
        if (nm == M_CU && m_mode != M_CU && m_cuc < 16'hFFFF) m_cuc++;
        if (nm == M_RST) m_locked = 1'b0;
        m_mode = nm;
    endtask

    // Spec-level model: signed distance in plain int arithmetic.
    task automatic model_step();
        bit rise, tgt;
        int d;
        if (!reset_n) begin
            m_mode = M_IDLE; m_ext = '0; m_prev = 0;
            m_locked = 0; m_err = 0; m_timer = 0;
            m_rsc = 0; m_cuc = 0;
            return;
        end
        rise = seq_external_valid && !m_prev;
        m_prev = seq_external_valid;
        tgt = (seq_internal == m_ext && v_ready) ||
              (seq_internal == m_ext - 32'd1 && !v_ready);
        m_err = 0;
        if (m_mode == M_CMP && !rise) begin
            d = int'(m_ext - seq_internal);
            if (d == 0) begin
                m_locked = 1; enter(M_IDLE);
            end else if (d > 0 && d <= LAG) enter(M_CU);
            else if (d < 0 && d >= -LEAD) enter(M_WAIT);
            else enter(M_RST);
        end else if (m_mode == M_CU || m_mode == M_WAIT) begin
            if (rise) begin
                m_locked = 0; enter(M_CMP);
            end else if (tgt) begin
                m_locked = 1; enter(M_IDLE);
            end
        end else if (m_mode == M_RST) begin
            m_timer = 0; enter(M_INIT);
        end else if (m_mode == M_INIT) begin
            if (init_done) enter(M_CMP);
            else if (m_timer == TMO - 1) begin
                m_err = 1; enter(M_RST);
            end else m_timer++;
        end else if (m_mode == M_IDLE && rise) begin
            enter(M_CMP);
        end
        if (rise) m_ext = seq_external;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("m_cu", catch_up_mode, 32'(m_mode == M_CU));
            check("m_gns", get_next_seed, 32'(m_mode == M_CU));
            check("m_blk", block_drbg_reseed, 32'(m_mode == M_WAIT));
            check("m_init", do_init, 32'(m_mode == M_INIT));
            check("m_lock", sync_locked, 32'(m_locked));
            check("m_err", sync_error, 32'(m_err));
            check("m_rnd", reset_n_drbg,
                  32'(reset_n && m_mode != M_RST));
`ifdef DRBG_SEQ_TRACKER_STATS_EN
            check("m_rsc", resync_count, 32'(m_rsc));
            check("m_cuc", catchup_count, 32'(m_cuc));
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=done");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] v);
        seq_external = v;
        seq_external_valid = 1'b1;
        step();
        seq_external_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    logic [31:0] cu_int [8] = '{100, 101, 101, 102, 102, 103, 103, 104};
    bit          cu_vr  [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    int n;

    initial begin
        reset_n = 1'b0;
        step();
        chk_en = 1'b1;
        check("rst_cu", catch_up_mode, 0);
        check("rst_rnd", reset_n_drbg, 0);
        reset_n = 1'b1;
        step();
        check("rel_rnd", reset_n_drbg, 1);
        check("rel_lock", sync_locked, 0);

        // Catch-up: int 100, ext 105.
        seq_internal = 100; v_ready = 0;
        pulse(105);
        step();
        check("cu_gns_on", get_next_seed, 1);
        for (int i = 0; i < 7; i++) begin
            seq_internal = cu_int[i]; v_ready = cu_vr[i];
            step();
        end
        seq_internal = cu_int[7]; v_ready = cu_vr[7];
        check("cu_gns_last", get_next_seed, 1);
        step();
        check("cu_gns_off", get_next_seed, 0);
        check("cu_lock", sync_locked, 1);

        // Lead: int 130, ext 100.
        seq_internal = 130; v_ready = 1;
        pulse(100);
        step();
        check("ld_blk_on", block_drbg_reseed, 1);
        step(); step(); step();
        seq_internal = 100; v_ready = 1;
        check("ld_blk_hold", block_drbg_reseed, 1);
        step();
        check("ld_blk_off", block_drbg_reseed, 0);
        check("ld_lock", sync_locked, 1);

        // Wrap: int FFFFFFFE, ext 2 gives +4.
        seq_internal = 32'hFFFF_FFFE; v_ready = 0;
        pulse(32'h2);
        step();
        check("wr_cu", catch_up_mode, 1);
        check("wr_rnd", reset_n_drbg, 1);
        seq_internal = 32'h1; v_ready = 0;
        step();
        check("wr_cu_off", catch_up_mode, 0);
        check("wr_lock", sync_locked, 1);

        // Rise beats target in the same cycle.
        seq_internal = 100; v_ready = 0;
        pulse(110);
        step();
        check("pr_cu", catch_up_mode, 1);
        seq_internal = 109;
        pulse(109);
        check("pr_cu_off", catch_up_mode, 0);
        check("pr_unlock", sync_locked, 0);
        step();
        check("pr_lock", sync_locked, 1);

        // Far lead: int 200, ext 100.
        seq_internal = 200; v_ready = 1;
        pulse(100);
        step();
        check("fl_rnd_lo", reset_n_drbg, 0);
        check("fl_unlock", sync_locked, 0);
        step();
        check("fl_rnd_hi", reset_n_drbg, 1);
        check("fl_init", do_init, 1);
        step(); step(); step();
        check("fl_init_hold", do_init, 1);
        seq_internal = 100; init_done = 1;
        step();
        init_done = 0;
        check("fl_init_off", do_init, 0);
        step();
        check("fl_lock", sync_locked, 1);

        // Timeout with init_done held low.
        do_reset();
        seq_internal = 500; v_ready = 1;
        pulse(100);
        step();
        step();
        check("to_init", do_init, 1);
        n = 0;
        while (!sync_error && n < 5000) begin
            step();
            n++;
        end
        check("to_cycles", n, TMO);
        check("to_rnd_lo", reset_n_drbg, 0);
`ifdef DRBG_SEQ_TRACKER_STATS_EN
        check("to_rsc", resync_count, 2);
`endif
        step();
        check("to_err_off", sync_error, 0);
        check("to_reinit", do_init, 1);
        seq_internal = 100; init_done = 1;
        step();
        init_done = 0;
        step();
        check("to_lock", sync_locked, 1);

        // Reset mid catch-up.
        seq_internal = 100; v_ready = 0;
        pulse(200);
        step();
        check("mr_cu", catch_up_mode, 1);
        reset_n = 1'b0;
        #1;
        check("mr_cu0", catch_up_mode, 0);
        check("mr_gns0", get_next_seed, 0);
        check("mr_lock0", sync_locked, 0);
        check("mr_rnd0", reset_n_drbg, 0);
        step();
        reset_n = 1'b1;
        step();
        check("mr_idle_cu", catch_up_mode, 0);
        check("mr_rnd1", reset_n_drbg, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/drbg_seq_tracker.md
DRBG_SEQ_TRACKER -- requirements
Module: drbg_seq_tracker

Interface
REQ-001 SHALL have parameter SEQ_W, default 32, the sequence number width in bits.
REQ-002 SHALL have parameter MAX_LEAD, default 60, the largest internal-ahead distance resolved by waiting.
REQ-003 SHALL have parameter MAX_LAG, default 1024, the largest internal-behind distance resolved by catch-up.
REQ-004 SHALL have parameter INIT_TIMEOUT, default 4096, the clk cycles allowed for init_done after reset release.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; every register is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port init_done, input, 1 bit: DRBG instantiate complete.
REQ-008 SHALL have port seq_internal, input, SEQ_W bits: local DRBG sequence number.
REQ-009 SHALL have port seq_external, input, SEQ_W bits: received sequence number.
REQ-010 SHALL have port seq_external_valid, input, 1 bit: level strobe; its rising edge qualifies seq_external.
REQ-011 SHALL have port v_ready, input, 1 bit: DRBG V updated for the current seq_internal.
REQ-012 SHALL have outputs catch_up_mode, get_next_seed, do_init, block_drbg_reseed, sync_locked and sync_error, each 1 bit.
REQ-013 SHALL have output reset_n_drbg, 1 bit: reset_n AND the internal drbg-reset command.

Function
REQ-014 SHALL register the seq_external_valid rise and store seq_external into ext_store in the same cycle.
REQ-015 SHALL compute delta = (ext_store - seq_internal) mod 2^SEQ_W and interpret it as signed SEQ_W, so wrap-around is handled (ext 0x00000002, int 0xFFFFFFFE gives delta +4).
REQ-016 SHALL use states IDLE, COMPARE, CATCH_UP, WAIT, RESET, INIT and treat any unlisted encoding as IDLE.
REQ-017 SHALL go from IDLE to COMPARE on a qualified rise.
REQ-018 SHALL make COMPARE last exactly 1 cycle and then branch as follows:
 - delta==0: IDLE, sync_locked=1.
 - 0<delta<=MAX_LAG: CATCH_UP.
 - -MAX_LEAD<=delta<0: WAIT.
 - otherwise: RESET.
REQ-019 SHALL hold catch_up_mode=1 and get_next_seed=1 in CATCH_UP until target is met, where target = (seq_internal==ext_store && v_ready) || (seq_internal==ext_store-1 && !v_ready).
REQ-020 SHALL on target met clear both outputs in the following cycle, go to IDLE and set sync_locked=1.
REQ-021 SHALL hold block_drbg_reseed=1 in WAIT until target is met, then clear it, go to IDLE and set sync_locked=1.
REQ-022 SHALL in RESET drive the drbg-reset command low for exactly 1 cycle, clear sync_locked, then enter INIT.
REQ-023 SHALL in INIT hold do_init=1 until init_done, then clear do_init and go to COMPARE (re-check against ext_store).
REQ-024 SHALL on INIT timeout (INIT_TIMEOUT cycles without init_done) pulse sync_error for 1 cycle and go to RESET (retry).
REQ-025 SHALL on a qualified rise in CATCH_UP or WAIT update ext_store, drop to COMPARE and clear sync_locked.
REQ-026 SHALL on a qualified rise in RESET or INIT update ext_store only; the comparison happens after INIT via REQ-023.
REQ-027 SHALL on a qualified rise in the same cycle as target met give priority to the rise.
REQ-028 SHALL register every output; there are no combinational paths from inputs to outputs except reset_n into reset_n_drbg.

Reset
REQ-029 SHALL on reset_n low clear state to IDLE, ext_store to 0 and every output except reset_n_drbg to 0, and hold the internal drbg-reset command at 1.
REQ-030 SHALL force reset_n_drbg low immediately and asynchronously while reset_n is low.
REQ-031 SHALL abandon any operation in progress when reset asserts mid-operation, with no pending-request memory.

Configuration
REQ-032 SHALL with DRBG_SEQ_TRACKER_STATS_EN defined add outputs resync_count[15:0], incremented on each RESET entry, and catchup_count[15:0], incremented on each CATCH_UP entry; both saturate at 0xFFFF and clear on reset.
REQ-033 SHALL without DRBG_SEQ_TRACKER_STATS_EN omit these ports and counters, with behaviour otherwise identical.

Structure
REQ-034 SHALL place state encodings and default parameter constants in a shared package drbg_sync_pkg, used by any block that decodes tracker state.
REQ-035 SHALL implement the wrap-aware delta and region classification (zero/lag/lead/reset) as sub-module drbg_seq_delta, which is purely combinational.

Verification
REQ-036 SHALL cover catch-up: int=100, ext=105, then model steps int with v_ready toggling -> get_next_seed high until int=104 with !v_ready, cleared the next cycle, sync_locked=1.
REQ-037 SHALL cover lead: int=130, ext=100 -> WAIT, block_drbg_reseed=1, until int==100 with v_ready -> block cleared, sync_locked=1.
REQ-038 SHALL cover far lead: int=200, ext=100 -> reset_n_drbg low for 1 cycle, do_init high until init_done, then COMPARE.
REQ-039 SHALL cover wrap: int=0xFFFFFFFE, ext=0x00000002 -> CATCH_UP, not RESET.
REQ-040 SHALL cover timeout: init_done held low for 4096 cycles -> sync_error 1-cycle pulse and RESET re-entered; resync_count=2 with DRBG_SEQ_TRACKER_STATS_EN defined.
REQ-041 SHALL cover reset mid-CATCH_UP: reset_n low -> all outputs 0 and reset_n_drbg 0 in the same cycle.
